// File: rtl/l2_port_arbiter.sv
// Two-client round-robin front end for the L2 L1-side port: client 0 is the I-cache, client 1 the D-cache.
// Captures the granted request, holds it on the L2 port until l2_ready, and returns the response to its owner.
module l2_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int BLOCK_SIZE = 32,
  parameter int TIMEOUT    = 1023,
  parameter int CNT_WIDTH  = 16,
  localparam int BLK_W     = BLOCK_SIZE * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] c0_addr,
  input  logic [ADDR_WIDTH-1:0] c1_addr,
  input  logic [BLK_W-1:0]      c0_data_in,
  input  logic [BLK_W-1:0]      c1_data_in,
  input  logic                  c0_read,
  input  logic                  c0_write,
  input  logic                  c1_read,
  input  logic                  c1_write,
  output logic                  c0_ready,
  output logic                  c1_ready,
  output logic                  c0_hit,
  output logic                  c1_hit,
  output logic                  c0_block_valid,
  output logic                  c1_block_valid,
  output logic [BLK_W-1:0]      c0_block_data,
  output logic [BLK_W-1:0]      c1_block_data,
  output logic [ADDR_WIDTH-1:0] l2_addr,
  output logic [BLK_W-1:0]      l2_data_in,
  output logic                  l2_read,
  output logic                  l2_write,
  input  logic                  l2_ready,
  input  logic                  l2_hit,
  input  logic                  l2_block_valid,
  input  logic [BLK_W-1:0]      l2_block_data,
  output logic                  timeout_err,
  output logic [CNT_WIDTH-1:0]  c0_grants,
  output logic [CNT_WIDTH-1:0]  c1_grants,
  output logic [1:0]            fsm_state,
  output logic                  last_grant
);

  localparam int BC_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t                state, state_next;
  logic                  req0, req1, grant_valid, grant_owner;
  logic                  cap_owner, cap_op;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [BLK_W-1:0]      cap_data;
  logic [BC_W-1:0]       busy_cnt;

  // Handshake: a client holds read and/or write until its ready pulse; ready, hit,
  // block_valid and block_data are meaningful only in that single ready cycle.
  assign req0        = c0_read | c0_write;
  assign req1        = c1_read | c1_write;
  assign grant_valid = req0 | req1;
  assign fsm_state   = state;

  always_comb begin
    grant_owner = 1'b0;
    if (req0 && req1) grant_owner = ~last_grant;
    else if (req1)    grant_owner = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = BUSY;
      BUSY:    if (l2_ready) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes drop in the l2_ready cycle so L2 does not start a second tag check.
  always_comb begin
    l2_read    = 1'b0;
    l2_write   = 1'b0;
    l2_addr    = '0;
    l2_data_in = '0;
    if (state == BUSY) begin
      l2_read    = ~cap_op & ~l2_ready;
      l2_write   = cap_op & ~l2_ready;
      l2_addr    = cap_addr;
      l2_data_in = cap_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant     <= 1'b1;
      cap_owner      <= 1'b0;
      cap_op         <= 1'b0;
      cap_addr       <= '0;
      cap_data       <= '0;
      busy_cnt       <= '0;
      timeout_err    <= 1'b0;
      c0_grants      <= '0;
      c1_grants      <= '0;
      c0_ready       <= 1'b0;
      c0_hit         <= 1'b0;
      c0_block_valid <= 1'b0;
      c0_block_data  <= '0;
      c1_ready       <= 1'b0;
      c1_hit         <= 1'b0;
      c1_block_valid <= 1'b0;
      c1_block_data  <= '0;
    end else begin
      // Response registers are single-cycle: cleared unless loaded this cycle.
      c0_ready       <= 1'b0;
      c0_hit         <= 1'b0;
      c0_block_valid <= 1'b0;
      c0_block_data  <= '0;
      c1_ready       <= 1'b0;
      c1_hit         <= 1'b0;
      c1_block_valid <= 1'b0;
      c1_block_data  <= '0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            cap_owner  <= grant_owner;
            cap_addr   <= grant_owner ? c1_addr : c0_addr;
            cap_data   <= grant_owner ? c1_data_in : c0_data_in;
            cap_op     <= grant_owner ? c1_write : c0_write;
            last_grant <= grant_owner;
            busy_cnt   <= '0;
            if (!grant_owner && c0_grants != '1) c0_grants <= c0_grants + CNT_WIDTH'(1);
            if (grant_owner && c1_grants != '1)  c1_grants <= c1_grants + CNT_WIDTH'(1);
          end
        end
        BUSY: begin
          if (busy_cnt != BC_W'(TIMEOUT)) busy_cnt <= busy_cnt + BC_W'(1);
          if (busy_cnt >= BC_W'(TIMEOUT - 1)) timeout_err <= 1'b1;
          if (l2_ready) begin
            if (cap_owner) begin
              c1_ready       <= 1'b1;
              c1_hit         <= l2_hit;
              c1_block_valid <= l2_block_valid;
              c1_block_data  <= l2_block_data;
            end else begin
              c0_ready       <= 1'b1;
              c0_hit         <= l2_hit;
              c0_block_valid <= l2_block_valid;
              c0_block_data  <= l2_block_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Shares the single L1-side request port of the L2 cache between two L1 clients: client 0 is the I-cache, client 1 is the D-cache.
- Captures each granted request, drives it to L2 for the whole transaction, and returns the L2 response to the owning client only.
- Uses round-robin arbitration.
- Provides a busy watchdog and per-client saturating grant counters for debug.

Parameters:
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 11, address width.
- BLOCK_SIZE, 32, words per block. BLK_W = BLOCK_SIZE*DATA_WIDTH.
- TIMEOUT, 1023, maximum BUSY cycles before the error flag sets.
- CNT_WIDTH, 16, width of each grant counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- c0_addr, c1_addr  in  ADDR_WIDTH  client request address.
- c0_data_in, c1_data_in  in  BLK_W  client write block.
- c0_read, c1_read  in  1  read request, held until the client's ready.
- c0_write, c1_write  in  1  write request, held until the client's ready.
- c0_ready, c1_ready  out  1  one-cycle completion pulse.
- c0_hit, c1_hit  out  1  L2 hit flag, valid with ready.
- c0_block_valid, c1_block_valid  out  1  block data valid, valid with ready.
- c0_block_data, c1_block_data  out  BLK_W  returned block.
- l2_addr  out  ADDR_WIDTH  to L2 l1_cache_addr.
- l2_data_in  out  BLK_W  to L2 l1_cache_data_in.
- l2_read, l2_write  out  1  to L2 request strobes.
- l2_ready, l2_hit, l2_block_valid  in  1  from L2.
- l2_block_data  in  BLK_W  from L2.
- timeout_err  out  1  sticky watchdog flag.
- c0_grants, c1_grants  out  CNT_WIDTH  saturating grant counters.

Behaviour:
- Reset (rst_n low at posedge), valid at any point including mid-transaction:
  - State becomes IDLE; last_grant=1.
  - All outputs go to 0: c*_ready/hit/block_valid/block_data, l2_addr, l2_data_in, l2_read, l2_write, timeout_err, grant counters, busy counter.
  - Any in-flight transaction is abandoned with no client response.
- Client request = read|write. If a client asserts both read and write, it is treated as a write.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One requester: grant it.
  - Both requesting: grant !last_grant (round-robin). The first tie after reset goes to client 0.
  - On grant, register into capture regs: owner, addr, data_in, op (1=write). Set last_grant=owner, increment that client's grant counter (saturate at all-ones), clear the busy counter, go to BUSY.
  - The L2 request is first visible in the cycle after the grant.
- BUSY:
  - l2_addr and l2_data_in are driven from the capture regs.
  - l2_read = BUSY & !op & !l2_ready; l2_write = BUSY & op & !l2_ready. These are combinational so L2 does not re-enter tag check in the cycle its ready arrives.
  - Busy counter increments every cycle.
  - On l2_ready: register l2_hit, l2_block_valid and l2_block_data into the owner's response outputs, pulse the owner's c*_ready in the next cycle, go to RESP.
  - Client inputs are ignored during BUSY; a changing input does not alter the captured request.
- RESP:
  - Owner's ready/hit/block_valid/block_data are high/valid for exactly this one cycle, then return to 0.
  - The non-owner's response outputs stay 0.
  - Next state is always IDLE. This gives the client one cycle to drop its request, so a request is never granted twice.
- Latency:
  - L2 hit read: 4 cycles from client request to client ready: grant, TAG_CHECK, L2 ready, RESP.
  - Miss: adds the L2/memory fill time.
  - Minimum gap between grants: 3 cycles.
- Watchdog: if the busy counter reaches TIMEOUT while in BUSY, timeout_err sets. It is sticky until reset. The FSM keeps waiting; there is no abort.
- Outputs l2_addr and l2_data_in are 0 in IDLE and RESP.
- A request arriving in RESP, or held from BUSY by the other client, is arbitrated in the following IDLE cycle.

Test Plan:
- Reset, then c0 read addr 0x040 alone; L2 model returns hit with block pattern 0xA5A5_0000+i → c0_ready, c0_hit, c0_block_valid pulse once, 4 cycles after the request; c0_block_data matches; c1 outputs stay 0; c0_grants=1.
- c0 read and c1 write asserted in the same cycle from reset → c0 served first, then c1; l2_write=1 with l2_addr=c1_addr; c1_ready follows; last_grant=1.
- Both clients hold requests continuously for 6 transactions → grants alternate 0,1,0,1,0,1; c0_grants=c1_grants=3; l2_read/l2_write are never high in an l2_ready cycle.
- Read miss with L2 ready delayed 20 cycles; c0_addr changed mid-BUSY → l2_addr holds the captured value; c0_block_data equals l2_block_data; no timeout_err.
- TIMEOUT=15 and L2 never asserts ready → timeout_err=1 after 15 BUSY cycles; rst_n low one cycle → everything is 0 and state is IDLE; a new c1 request is then granted normally.
- Grant counter saturation with CNT_WIDTH=2: 5 c0 transactions → c0_grants sticks at 3.
